// File: rtl/pe_seq_ctrl.sv
// rtl/pe_seq_ctrl.sv - PE sequencer: LOAD, COMPUTE/TRANSMIT/SHIFT iterations, OUTPUT.
// Define PE_SEQ_PERF_EN to add the stall_cnt and job_cycles performance counters.
module pe_seq_ctrl #(
    parameter int LOAD_NUM      = 32,
    parameter int INST_NUM      = 64,
    parameter int TX_NUM        = 4,
    parameter int REG_NUM       = 16,
    parameter int OUT_NUM       = 4,
    parameter int ITER_W        = 7,
    parameter int IM_ADDR_WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     din_pe_v,
    input  logic [ITER_W-1:0]        iter_num,
    input  logic                     abort,
    input  logic                     tx_rdy,
    input  logic                     out_rdy,
    output logic                     load_v,
    output logic                     cmpt_v,
    output logic [IM_ADDR_WIDTH-1:0] inst_addr,
    output logic                     tx_v,
    output logic                     shift_v,
    output logic                     output_v,
    output logic [ITER_W-1:0]        iter_idx,
    output logic                     last_iter,
    output logic                     busy,
`ifdef PE_SEQ_PERF_EN
    output logic [15:0]              stall_cnt,
    output logic [15:0]              job_cycles,
`endif
    output logic                     done
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_COMPUTE  = 3'd2;
    localparam logic [2:0] S_TRANSMIT = 3'd3;
    localparam logic [2:0] S_SHIFT    = 3'd4;
    localparam logic [2:0] S_OUTPUT   = 3'd5;

    localparam int MAX_A   = (LOAD_NUM > INST_NUM) ? LOAD_NUM : INST_NUM;
    localparam int MAX_B   = (TX_NUM > REG_NUM) ? TX_NUM : REG_NUM;
    localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_NUM = (MAX_C > OUT_NUM) ? MAX_C : OUT_NUM;
    localparam int CNT_W   = $clog2(MAX_NUM + 1);

    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_NUM - 1);
    localparam logic [CNT_W-1:0] INST_LAST = CNT_W'(INST_NUM - 1);
    localparam logic [CNT_W-1:0] TX_LAST   = CNT_W'(TX_NUM - 1);
    localparam logic [CNT_W-1:0] REG_LAST  = CNT_W'(REG_NUM - 1);
    localparam logic [CNT_W-1:0] OUT_LAST  = CNT_W'(OUT_NUM - 1);

    logic [2:0]               state;
    logic [CNT_W-1:0]         cnt;
    logic [IM_ADDR_WIDTH-1:0] addr_q;
    logic [ITER_W-1:0]        iter_idx_q;
    logic [ITER_W-1:0]        iter_cnt;
    logic                     done_q;
    logic                     start;

    assign start = (state == S_IDLE) && din_pe_v && !abort;

    assign load_v    = (state == S_LOAD);
    assign cmpt_v    = (state == S_COMPUTE);
    assign tx_v      = (state == S_TRANSMIT);
    assign shift_v   = (state == S_SHIFT);
    assign output_v  = (state == S_OUTPUT);
    assign busy      = (state != S_IDLE);
    assign inst_addr = addr_q;
    assign iter_idx  = iter_idx_q;
    assign done      = done_q;
    // Gated by busy so the reset value of iter_cnt (1) does not flag IDLE as a last iteration.
    assign last_iter = busy && (iter_idx_q == (iter_cnt - ITER_W'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            iter_idx_q <= '0;
            iter_cnt   <= ITER_W'(1);
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort && state != S_IDLE) begin
                state      <= S_IDLE;
                cnt        <= '0;
                addr_q     <= '0;
                iter_idx_q <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        iter_idx_q <= '0;
                        if (start) begin
                            iter_cnt <= (iter_num == '0) ? ITER_W'(1) : iter_num;
                            cnt      <= '0;
                            state    <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        if (cnt == LOAD_LAST) begin
                            cnt    <= '0;
                            addr_q <= '0;
                            state  <= S_COMPUTE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    S_COMPUTE: begin
                        if (cnt == INST_LAST) begin
                            cnt    <= '0;
                            addr_q <= '0;
                            state  <= last_iter ? S_OUTPUT : S_TRANSMIT;
                        end else begin
                            cnt    <= cnt + CNT_W'(1);
                            addr_q <= addr_q + IM_ADDR_WIDTH'(1);
                        end
                    end
                    S_TRANSMIT: begin
                        if (tx_rdy) begin
                            if (cnt == TX_LAST) begin
                                cnt   <= '0;
                                state <= S_SHIFT;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end
                    S_SHIFT: begin
                        if (cnt == REG_LAST) begin
                            cnt        <= '0;
                            addr_q     <= '0;
                            iter_idx_q <= iter_idx_q + ITER_W'(1);
                            state      <= S_COMPUTE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    S_OUTPUT: begin
                        if (out_rdy) begin
                            if (cnt == OUT_LAST) begin
                                cnt        <= '0;
                                iter_idx_q <= '0;
                                done_q     <= 1'b1;
                                state      <= S_IDLE;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

`ifdef PE_SEQ_PERF_EN
    logic [15:0] run_cnt;
    logic        stall_now;

    assign stall_now = (tx_v && !tx_rdy) || (output_v && !out_rdy);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt  <= '0;
            job_cycles <= '0;
            run_cnt    <= '0;
        end else begin
            if (start) begin
                stall_cnt <= '0;
                run_cnt   <= '0;
            end else if (busy) begin
                if (run_cnt != 16'hFFFF) run_cnt <= run_cnt + 16'd1;
                if (stall_now && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
            end
            // done rises in the first IDLE cycle, so run_cnt already holds the full job length.
            if (done_q) job_cycles <= run_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// tb/tb_pe_seq_ctrl.sv - scoreboard bench for pe_seq_ctrl (phase trace per cycle).
module tb_pe_seq_ctrl;

    localparam int LOAD_NUM = 4;
    localparam int INST_NUM = 8;
    localparam int TX_NUM   = 2;
    localparam int REG_NUM  = 3;
    localparam int OUT_NUM  = 2;
    localparam int ITER_W   = 7;
    localparam int IMW      = 3;
    localparam int VW       = 8 + ITER_W + IMW;
    localparam int JOB3     = LOAD_NUM + 3 * INST_NUM + 2 * (TX_NUM + REG_NUM) + OUT_NUM;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              din_pe_v = 1'b0;
    logic [ITER_W-1:0] iter_num = '0;
    logic              abort = 1'b0;
    logic              tx_rdy = 1'b1;
    logic              out_rdy = 1'b1;
    logic              load_v, cmpt_v, tx_v, shift_v, output_v, last_iter, busy, done;
    logic [IMW-1:0]    inst_addr;
    logic [ITER_W-1:0] iter_idx;
`ifdef PE_SEQ_PERF_EN
    logic [15:0]       stall_cnt, job_cycles;
`endif

    pe_seq_ctrl #(
        .LOAD_NUM(LOAD_NUM), .INST_NUM(INST_NUM), .TX_NUM(TX_NUM), .REG_NUM(REG_NUM),
        .OUT_NUM(OUT_NUM), .ITER_W(ITER_W), .IM_ADDR_WIDTH(IMW)
    ) dut (
        .clk(clk), .rst(rst), .din_pe_v(din_pe_v), .iter_num(iter_num), .abort(abort),
        .tx_rdy(tx_rdy), .out_rdy(out_rdy), .load_v(load_v), .cmpt_v(cmpt_v),
        .inst_addr(inst_addr), .tx_v(tx_v), .shift_v(shift_v), .output_v(output_v),
        .iter_idx(iter_idx), .last_iter(last_iter), .busy(busy),
`ifdef PE_SEQ_PERF_EN
        .stall_cnt(stall_cnt), .job_cycles(job_cycles),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    logic [VW-1:0] exp_q[$];
    logic [VW-1:0] exp_v;
    int gen_c, gen_lim;

    function automatic logic [VW-1:0] mk(input bit b, input bit d, input bit ld, input bit cm,
                                         input bit tx, input bit sh, input bit ov, input bit lst,
                                         input int idx, input int addr);
        return {b, d, ld, cm, tx, sh, ov, lst, ITER_W'(idx), IMW'(addr)};
    endfunction

    function automatic logic [VW-1:0] obs();
        return {busy, done, load_v, cmpt_v, tx_v, shift_v, output_v, last_iter, iter_idx, inst_addr};
    endfunction

    task automatic push_c(input logic [VW-1:0] v);
        if (gen_c < gen_lim) exp_q.push_back(v);
        gen_c++;
    endtask

    // Expected per-cycle trace of a job with n effective iterations, extra stalled beats
    // in the first TRANSMIT / in OUTPUT, truncated to the first 'limit' cycles after start.
    task automatic push_job(input int n, input int tx_stall, input int out_stall, input int limit);
        gen_c = 0;
        gen_lim = limit;
        for (int i = 0; i < LOAD_NUM; i++) push_c(mk(1, 0, 1, 0, 0, 0, 0, n == 1, 0, 0));
        for (int it = 0; it < n; it++) begin
            for (int k = 0; k < INST_NUM; k++) push_c(mk(1, 0, 0, 1, 0, 0, 0, it == n - 1, it, k));
            if (it < n - 1) begin
                for (int s = 0; s < TX_NUM + ((it == 0) ? tx_stall : 0); s++)
                    push_c(mk(1, 0, 0, 0, 1, 0, 0, 0, it, 0));
                for (int s = 0; s < REG_NUM; s++) push_c(mk(1, 0, 0, 0, 0, 1, 0, 0, it, 0));
            end
        end
        for (int s = 0; s < OUT_NUM + out_stall; s++) push_c(mk(1, 0, 0, 0, 0, 0, 1, 1, n - 1, 0));
        push_c(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        push_c('0);
    endtask

    task automatic idle_inputs();
        din_pe_v = 1'b0; abort = 1'b0; rst = 1'b0; tx_rdy = 1'b1; out_rdy = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; din_pe_v = 1'b1; iter_num = 7'd3;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_chk++;
            if (obs() !== '0) begin
                n_fail++; $display("FAIL reset_state cyc %0d: got %h expected %h", c, obs(), {VW{1'b0}});
            end
`ifdef PE_SEQ_PERF_EN
            n_chk++;
            if (stall_cnt !== 16'd0 || job_cycles !== 16'd0) begin
                n_fail++; $display("FAIL reset_perf: got %0d/%0d expected 0/0", stall_cnt, job_cycles);
            end
`endif
        end
        idle_inputs();
        @(posedge clk); #1;
        n_chk++;
        if (obs() !== '0) begin
            n_fail++; $display("FAIL reset_idle: got %h expected %h", obs(), {VW{1'b0}});
        end
    endtask

    // Three iterations; din_pe_v held during busy and iter_num changed mid-job must not matter.
    task automatic test_basic();
        int c = 0;
        push_job(3, 0, 0, 1000);
        din_pe_v = 1'b1; iter_num = 7'd3;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1; c++;
            din_pe_v = (c <= JOB3);
            iter_num = 7'd1;
            exp_v = exp_q.pop_front(); n_chk++;
            if (obs() !== exp_v) begin
                n_fail++; $display("FAIL basic cyc %0d: got %h expected %h", c, obs(), exp_v);
            end
        end
        idle_inputs();
    endtask

    task automatic test_iter_zero();
        int c = 0;
        push_job(1, 0, 0, 1000);
        din_pe_v = 1'b1; iter_num = 7'd0;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1; c++;
            din_pe_v = 1'b0;
            exp_v = exp_q.pop_front(); n_chk++;
            if (obs() !== exp_v) begin
                n_fail++; $display("FAIL iter_zero cyc %0d: got %h expected %h", c, obs(), exp_v);
            end
        end
        idle_inputs();
    endtask

    task automatic test_tx_stall();
        int c = 0;
        push_job(3, 5, 0, 1000);
        din_pe_v = 1'b1; iter_num = 7'd3;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1; c++;
            din_pe_v = 1'b0;
            tx_rdy = !(c >= LOAD_NUM + INST_NUM + 1 && c <= LOAD_NUM + INST_NUM + 5);
            exp_v = exp_q.pop_front(); n_chk++;
            if (obs() !== exp_v) begin
                n_fail++; $display("FAIL tx_stall cyc %0d: got %h expected %h", c, obs(), exp_v);
            end
        end
`ifdef PE_SEQ_PERF_EN
        n_chk++;
        if (stall_cnt !== 16'd5) begin
            n_fail++; $display("FAIL stall_cnt: got %0d expected 5", stall_cnt);
        end
        n_chk++;
        if (job_cycles !== 16'(JOB3 + 5)) begin
            n_fail++; $display("FAIL job_cycles: got %0d expected %0d", job_cycles, JOB3 + 5);
        end
`endif
        idle_inputs();
    endtask

    // Abort at inst_addr 3 of iteration 1, then abort+start in IDLE, then a clean restart.
    task automatic test_abort();
        int c = 0;
        int abort_c = LOAD_NUM + INST_NUM + TX_NUM + REG_NUM + 4;
        push_job(3, 0, 0, abort_c);
        for (int i = 0; i < 3; i++) exp_q.push_back('0);
        din_pe_v = 1'b1; iter_num = 7'd3;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1; c++;
            din_pe_v = 1'b0;
            abort = (c == abort_c);
            exp_v = exp_q.pop_front(); n_chk++;
            if (obs() !== exp_v) begin
                n_fail++; $display("FAIL abort cyc %0d: got %h expected %h", c, obs(), exp_v);
            end
        end
        c = 0;
        exp_q.push_back('0);
        push_job(1, 0, 0, 1000);
        din_pe_v = 1'b1; abort = 1'b1; iter_num = 7'd1;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1; c++;
            din_pe_v = (c == 1);
            abort = 1'b0;
            exp_v = exp_q.pop_front(); n_chk++;
            if (obs() !== exp_v) begin
                n_fail++; $display("FAIL abort_restart cyc %0d: got %h expected %h", c, obs(), exp_v);
            end
        end
        idle_inputs();
    endtask

    task automatic test_rst_output();
        int c = 0;
        int out_c = LOAD_NUM + INST_NUM + 1;
        push_job(1, 0, 3, out_c + 2);
        for (int i = 0; i < 3; i++) exp_q.push_back('0);
        din_pe_v = 1'b1; iter_num = 7'd1;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1; c++;
            din_pe_v = 1'b0;
            out_rdy = (c < out_c) || (c > out_c + 2);
            rst = (c == out_c + 2);
            exp_v = exp_q.pop_front(); n_chk++;
            if (obs() !== exp_v) begin
                n_fail++; $display("FAIL rst_output cyc %0d: got %h expected %h", c, obs(), exp_v);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_iter_zero();
        test_tx_stall();
        test_abort();
        test_rst_output();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
